// File: rtl/spike_event_encoder_pkg.sv
// Shared constants for the spike event encoder: FSM encodings and event field layout.
package spike_event_encoder_pkg;

    localparam logic [0:0] SE_IDLE = 1'b0;
    localparam logic [0:0] SE_SCAN = 1'b1;

    // Packed event layout is {addr, step, last}.
    function automatic int unsigned evt_width(input int unsigned addr_w, input int unsigned step_w);
        return addr_w + step_w + 1;
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible whenever not empty.
module spike_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a full FIFO may still take a push in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Converts each closed spike window into ascending address events, buffered behind valid/ready.
module spike_event_encoder
    import spike_event_encoder_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned STEP_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   time_step,
    input  logic [NUM_NEURONS-1:0] spikes,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [STEP_W-1:0]      out_step,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
    localparam int unsigned EVT_W = evt_width(ADDR_W, STEP_W);

    logic [0:0]             state,    state_nxt;
    logic [NUM_NEURONS-1:0] pending,  pending_nxt;
    logic [NUM_NEURONS-1:0] scan,     scan_nxt;
    logic [STEP_W-1:0]      step_cnt, step_nxt;
    logic [STEP_W-1:0]      tag,      tag_nxt;
    logic                   defer,    defer_nxt;
    logic                   overrun_nxt;

    logic [NUM_NEURONS-1:0] lowest_c;
    logic [IDX_W-1:0]       idx_c;
    logic                   last_c;
    logic                   push_c;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [EVT_W-1:0]       fifo_din;
    logic [EVT_W-1:0]       fifo_dout;

    // Priority encoder: isolate and index the lowest pending bit of the window being scanned.
    always_comb begin
        lowest_c = scan & (~scan + NUM_NEURONS'(1));
        last_c   = ((scan & ~lowest_c) == '0);
        idx_c    = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (scan[i]) idx_c = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SE_IDLE;
            pending  <= '0;
            scan     <= '0;
            step_cnt <= '0;
            tag      <= '0;
            defer    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            scan     <= scan_nxt;
            step_cnt <= step_nxt;
            tag      <= tag_nxt;
            defer    <= defer_nxt;
            overrun  <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending | spikes;
        scan_nxt    = scan;
        step_nxt    = step_cnt;
        tag_nxt     = tag;
        defer_nxt   = defer;
        overrun_nxt = overrun;
        push_c      = 1'b0;
        case (state)
            SE_IDLE: begin
                // A deferred pulse is honoured here; a fresh pulse in the same cycle cannot also be.
                if (time_step || defer) begin
                    scan_nxt    = pending;
                    pending_nxt = spikes;
                    tag_nxt     = step_cnt;
                    step_nxt    = step_cnt + STEP_W'(1);
                    defer_nxt   = 1'b0;
                    if (time_step && defer) overrun_nxt = 1'b1;
                    if (pending != '0)      state_nxt   = SE_SCAN;
                end
            end
            SE_SCAN: begin
                if (time_step) begin
                    if (defer) overrun_nxt = 1'b1;
                    else       defer_nxt   = 1'b1;
                end
                if (!fifo_full) begin
                    push_c   = 1'b1;
                    scan_nxt = scan & ~lowest_c;
                    if (last_c) state_nxt = SE_IDLE;
                end
            end
            default: state_nxt = SE_IDLE;
        endcase
    end

    assign fifo_din = {ADDR_W'(BASE_ADDR) + ADDR_W'(idx_c), tag, last_c};

    spike_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (fifo_din),
        .pop   (out_valid && out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid                    = !fifo_empty;
    assign {out_addr, out_step, out_last} = fifo_dout;
    assign busy                         = (state == SE_SCAN) || defer;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: ordering, tagging, backpressure, deferral, reset.
module tb_spike_event_encoder;

    localparam int unsigned N     = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned SW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BASE  = 100;
    localparam int unsigned OBS_W = AW + SW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          time_step;
    logic [N-1:0]  spikes;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [SW-1:0] out_step;
    logic          out_last;
    logic          busy;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_event_encoder #(
        .NUM_NEURONS (N),
        .ADDR_W      (AW),
        .BASE_ADDR   (BASE),
        .STEP_W      (SW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .time_step (time_step),
        .spikes    (spikes),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_step  (out_step),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    wire [OBS_W-1:0] obs = {out_valid, out_addr, out_step, out_last};

    function automatic logic [OBS_W-1:0] ev(input int unsigned idx, input int unsigned tg, input logic last);
        return {1'b1, AW'(BASE + idx), SW'(tg), last};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; time_step = 1'b0; spikes = '0; out_ready = 1'b1;
        cyc(3);
        n_checks++;
        if ({obs, busy, overrun} !== '0) begin
            n_fail++; $display("FAIL reset_held: got %h expected 0", {obs, busy, overrun});
        end
        rst = 1'b0;
        cyc(2);
        n_checks++;
        if ({obs, busy, overrun} !== '0) begin
            n_fail++; $display("FAIL reset_released: got %h expected 0", {obs, busy, overrun});
        end
    endtask

    task automatic test_empty_window;
        time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        n_checks++;
        if ({obs, busy} !== '0) begin
            n_fail++; $display("FAIL empty_no_scan: got %h expected 0", {obs, busy});
        end
        spikes = 32'h20;
        cyc(1);
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL empty_no_event: got %h expected 0", obs);
        end
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        cyc(1);
        n_checks++;
        if (obs !== ev(5, 1, 1'b1)) begin
            n_fail++; $display("FAIL single_event: got %h expected %h", obs, ev(5, 1, 1'b1));
        end
        cyc(1);
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL single_drained: got %h expected 0", obs);
        end
    endtask

    task automatic test_scan_order;
        spikes = 32'h8; cyc(1);
        spikes = 32'h1; cyc(1);
        spikes = 32'h80; cyc(1);
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        n_checks++;
        if ({out_valid, busy} !== 2'b01) begin
            n_fail++; $display("FAIL order_t1: got %b expected 01", {out_valid, busy});
        end
        cyc(1);
        n_checks++;
        if (obs !== ev(0, 2, 1'b0)) begin
            n_fail++; $display("FAIL order_e0: got %h expected %h", obs, ev(0, 2, 1'b0));
        end
        cyc(1);
        n_checks++;
        if (obs !== ev(3, 2, 1'b0)) begin
            n_fail++; $display("FAIL order_e3: got %h expected %h", obs, ev(3, 2, 1'b0));
        end
        cyc(1);
        n_checks++;
        if (obs !== ev(7, 2, 1'b1)) begin
            n_fail++; $display("FAIL order_e7: got %h expected %h", obs, ev(7, 2, 1'b1));
        end
        cyc(1);
        n_checks++;
        if ({obs, busy} !== '0) begin
            n_fail++; $display("FAIL order_done: got %h expected 0", {obs, busy});
        end
    endtask

    task automatic test_same_cycle_spike;
        spikes = 32'h2; cyc(1);
        spikes = 32'h4; time_step = 1'b1;
        cyc(1);
        spikes = '0; time_step = 1'b0;
        cyc(1);
        n_checks++;
        if (obs !== ev(1, 3, 1'b1)) begin
            n_fail++; $display("FAIL same_cycle_old: got %h expected %h", obs, ev(1, 3, 1'b1));
        end
        cyc(1);
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL same_cycle_excluded: got %h expected 0", obs);
        end
        time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        cyc(1);
        n_checks++;
        if (obs !== ev(2, 4, 1'b1)) begin
            n_fail++; $display("FAIL same_cycle_new: got %h expected %h", obs, ev(2, 4, 1'b1));
        end
        cyc(1);
    endtask

    task automatic test_backpressure;
        int k;
        k = 0;
        out_ready = 1'b0; spikes = '1;
        cyc(1);
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        cyc(4);
        n_checks++;
        if (obs !== ev(0, 5, 1'b0)) begin
            n_fail++; $display("FAIL bp_head_early: got %h expected %h", obs, ev(0, 5, 1'b0));
        end
        cyc(25);
        n_checks++;
        if ({obs, busy} !== {ev(0, 5, 1'b0), 1'b1}) begin
            n_fail++; $display("FAIL bp_stalled: got %h expected %h", {obs, busy}, {ev(0, 5, 1'b0), 1'b1});
        end
        out_ready = 1'b1;
        for (int c = 0; c < 200 && k < 32; c++) begin
            if (out_valid) begin
                n_checks++;
                if (obs !== ev(k, 5, k == 31)) begin
                    n_fail++; $display("FAIL bp_event%0d: got %h expected %h", k, obs, ev(k, 5, k == 31));
                end
                k++;
            end
            cyc(1);
        end
        n_checks++;
        if (k != 32 || {obs, busy} !== '0) begin
            n_fail++; $display("FAIL bp_drain: got %0d events valid=%b busy=%b expected 32 0 0", k, out_valid, busy);
        end
    endtask

    task automatic test_overrun;
        int k;
        logic [OBS_W-1:0] exp_ev;
        k = 0;
        out_ready = 1'b0; spikes = '1;
        cyc(1);
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        cyc(20);
        spikes = 32'h10; cyc(1);
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        n_checks++;
        if ({busy, overrun} !== 2'b10) begin
            n_fail++; $display("FAIL ovr_deferred: got %b expected 10", {busy, overrun});
        end
        cyc(2);
        spikes = 32'h200; cyc(1);
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        n_checks++;
        if ({busy, overrun} !== 2'b11) begin
            n_fail++; $display("FAIL ovr_flag: got %b expected 11", {busy, overrun});
        end
        out_ready = 1'b1;
        for (int c = 0; c < 200 && k < 34; c++) begin
            if (out_valid) begin
                exp_ev = (k < 32) ? ev(k, 6, k == 31) : ((k == 32) ? ev(4, 7, 1'b0) : ev(9, 7, 1'b1));
                n_checks++;
                if (obs !== exp_ev) begin
                    n_fail++; $display("FAIL ovr_event%0d: got %h expected %h", k, obs, exp_ev);
                end
                k++;
            end
            cyc(1);
        end
        n_checks++;
        if (k != 34 || {obs, busy, overrun} !== {{OBS_W{1'b0}}, 2'b01}) begin
            n_fail++; $display("FAIL ovr_drain: got %0d events valid=%b busy=%b overrun=%b expected 34 0 0 1",
                               k, out_valid, busy, overrun);
        end
    endtask

    task automatic test_reset_mid_scan;
        out_ready = 1'b0; spikes = 32'he;
        cyc(1);
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({obs, busy, overrun} !== '0) begin
            n_fail++; $display("FAIL rst_async: got %h expected 0", {obs, busy, overrun});
        end
        cyc(1);
        rst = 1'b0; out_ready = 1'b1;
        cyc(3);
        n_checks++;
        if ({obs, busy} !== '0) begin
            n_fail++; $display("FAIL rst_no_stale: got %h expected 0", {obs, busy});
        end
        spikes = 32'h40; cyc(1);
        spikes = '0; time_step = 1'b1;
        cyc(1);
        time_step = 1'b0;
        cyc(1);
        n_checks++;
        if (obs !== ev(6, 0, 1'b1)) begin
            n_fail++; $display("FAIL rst_tag_restart: got %h expected %h", obs, ev(6, 0, 1'b1));
        end
        cyc(1);
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL rst_final_empty: got %h expected 0", obs);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty_window();
        test_scan_order();
        test_same_cycle_spike();
        test_backpressure();
        test_overrun();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
